// File: rtl/pdm_capture_pkg.sv
// Shared definitions for the PDM capture block: command encodings,
// capture state enum and the default buffer base address.
package pdm_capture_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        CAPT = 1'b1
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h4000_0000;

    // Both 10 and 11 clear; the clear bit alone decides.
    function automatic logic is_clear(input logic [1:0] cmd);
        return (cmd & CMD_CLEAR) != CMD_NONE;
    endfunction

endpackage

// File: rtl/pdm_capture_buf.sv
// Capture buffer: DEPTH x 32 simple dual-port RAM, one write port and one
// registered read port on the same clock. A read that hits the word being
// written in the same cycle returns the previous contents.
module pdm_capture_buf
    import pdm_capture_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Write port and registered read port; read sees pre-write data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pdm_capture.sv
// PDM microphone capture. PDMclk and pdm_signal are synchronized and
// PDMclk is edge-detected as data; bits are packed MSB-first into 32-bit
// words and stored in a DEPTH-word buffer readable by byte address.
// Optional build macro: PDM_DUAL_EDGE_EN -- also sample on PDMclk falling
// edges (stereo interleave, rising-edge bit first).
module pdm_capture
    import pdm_capture_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        AHBclk,
    input  logic        rst,
    input  logic        PDMclk,
    input  logic [1:0]  ctrl,
    input  logic [31:0] addr,
    input  logic        pdm_signal,
    output logic [31:0] dout,
    output logic        bsy
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] OFF_LIMIT = 32'(DEPTH * 4);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    logic [SYNC_STAGES-1:0] clk_sync_p0;
    logic [SYNC_STAGES-1:0] dat_sync_p0;
    logic                   clk_prev_p1;
    logic                   pdm_clk_s;
    logic                   pdm_bit;
    logic                   pdm_edge;

    state_t                 state;
    logic [AW-1:0]          ptr;
    logic [4:0]             cnt;
    logic [31:0]            shift;
    logic [31:0]            word_next;
    logic                   word_done;

    logic [31:0]            off;
    logic                   in_range;
    logic                   rng_p1;
    logic [31:0]            rd_data_p1;

    // Synchronize PDM clock and data, and keep last synchronized clock level.
    always_ff @(posedge AHBclk or negedge rst) begin
        if (!rst) begin
            clk_sync_p0 <= '0;
            dat_sync_p0 <= '0;
            clk_prev_p1 <= 1'b0;
        end else begin
            clk_sync_p0 <= {clk_sync_p0[SYNC_STAGES-2:0], PDMclk};
            dat_sync_p0 <= {dat_sync_p0[SYNC_STAGES-2:0], pdm_signal};
            clk_prev_p1 <= clk_sync_p0[SYNC_STAGES-1];
        end
    end

    assign pdm_clk_s = clk_sync_p0[SYNC_STAGES-1];
    assign pdm_bit   = dat_sync_p0[SYNC_STAGES-1];

`ifdef PDM_DUAL_EDGE_EN
    assign pdm_edge = pdm_clk_s ^ clk_prev_p1;
`else
    assign pdm_edge = pdm_clk_s & ~clk_prev_p1;
`endif

    // A clear on the same cycle as a 32nd bit discards that word.
    assign word_next = {shift[30:0], pdm_bit};
    assign word_done = (state == CAPT) && pdm_edge && (cnt == 5'd31) && !is_clear(ctrl);

    // Capture FSM: command handling, bit packing and buffer pointer.
    always_ff @(posedge AHBclk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            bsy   <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
            shift <= '0;
        end else if (is_clear(ctrl)) begin
            state <= IDLE;
            bsy   <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl == CMD_START) begin
                        state <= CAPT;
                        bsy   <= 1'b1;
                        ptr   <= '0;
                        cnt   <= '0;
                        shift <= '0;
                    end
                end
                CAPT: begin
                    if (pdm_edge) begin
                        shift <= word_next;
                        if (cnt == 5'd31) begin
                            cnt <= '0;
                            ptr <= ptr + 1'b1;
                            if (ptr == LAST_WORD) begin
                                state <= IDLE;
                                bsy   <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign off      = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (off < OFF_LIMIT);

    pdm_capture_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (AHBclk),
        .we    (word_done),
        .waddr (ptr),
        .wdata (word_next),
        .raddr (off[AW+1:2]),
        .rdata (rd_data_p1)
    );

    // Register the address range decision alongside the RAM read.
    always_ff @(posedge AHBclk or negedge rst) begin
        if (!rst) begin
            rng_p1 <= 1'b0;
        end else begin
            rng_p1 <= in_range;
        end
    end

    assign dout = rng_p1 ? rd_data_p1 : 32'h0;

endmodule

// File: tb/tb_pdm_capture.sv
// Testbench for pdm_capture: directed sequences plus randomized full
// captures compared against a bit-queue model of the capture buffer.
module tb_pdm_capture;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h4000_0000;

    logic        AHBclk = 1'b0;
    logic        rst = 1'b0;
    logic        PDMclk = 1'b0;
    logic [1:0]  ctrl = 2'b00;
    logic [31:0] addr = BASE;
    logic        pdm_signal = 1'b0;
    logic [31:0] dout;
    logic        bsy;

    pdm_capture #(
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .AHBclk     (AHBclk),
        .rst        (rst),
        .PDMclk     (PDMclk),
        .ctrl       (ctrl),
        .addr       (addr),
        .pdm_signal (pdm_signal),
        .dout       (dout),
        .bsy        (bsy)
    );

    always #5 AHBclk = ~AHBclk;

    int errors = 0;
    int checks = 0;

    // Reference model: captured bits queue, expected buffer, busy flag.
    logic [31:0] m_mem [DEPTH];
    bit          m_busy = 0;
    int          m_ptr = 0;
    bit          m_bits [$];

    // Cycle monitor for the end-of-capture timing check.
    int          cyc = 0;
    bit          watch = 0;
    int          fall_cyc = -1;
    int          hit_cyc = -1;
    logic [31:0] target = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] e;
        string       n;
    } rd_vec_t;

    always @(negedge AHBclk) begin
        cyc++;
        if (watch) begin
            if (bsy === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
            if (dout === target && hit_cyc < 0) hit_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_start();
        if (!m_busy) begin
            m_busy = 1;
            m_ptr  = 0;
            m_bits.delete();
        end
    endtask

    task automatic model_clear();
        m_busy = 0;
        m_ptr  = 0;
        m_bits.delete();
    endtask

    task automatic model_bit(input bit b);
        logic [31:0] w;
        if (!m_busy) return;
        m_bits.push_back(b);
        if (m_bits.size() == 32) begin
            for (int i = 0; i < 32; i++) w[31-i] = m_bits[i];
            m_mem[m_ptr] = w;
            m_ptr++;
            m_bits.delete();
            if (m_ptr == DEPTH) m_busy = 0;
        end
    endtask

    task automatic cmd(input logic [1:0] c);
        @(negedge AHBclk);
        ctrl = c;
        if (c == 2'b01) model_start();
        else if (c[1]) model_clear();
        @(negedge AHBclk);
        ctrl = 2'b00;
    endtask

    // One PDM period: 2 cycles low, 2 cycles high, data stable throughout.
    task automatic send_bit(input bit b);
        @(negedge AHBclk);
        pdm_signal = b;
        PDMclk = 1'b0;
        repeat (2) @(negedge AHBclk);
        PDMclk = 1'b1;
        model_bit(b);
        @(negedge AHBclk);
    endtask

    task automatic settle();
        repeat (6) @(negedge AHBclk);
    endtask

    task automatic read(input logic [31:0] a, output logic [31:0] d);
        @(negedge AHBclk);
        addr = a;
        @(negedge AHBclk);
        d = dout;
    endtask

    initial begin
        logic [31:0] d;
        bit          cap_bits [DEPTH*32];
        rd_vec_t     tbl [6];

        // Reset state
        repeat (3) @(negedge AHBclk);
        check("reset_dout", dout, 32'h0);
        check("reset_bsy", 32'(bsy), 32'h0);
        @(negedge AHBclk);
        rst = 1'b1;
        repeat (3) @(negedge AHBclk);
        check("bsy_after_release", 32'(bsy), 32'h0);

        // Clear, start, 32 ones
        cmd(2'b10);
        @(negedge AHBclk);
        ctrl = 2'b01;
        model_start();
        check("bsy_before_start_edge", 32'(bsy), 32'h0);
        @(negedge AHBclk);
        ctrl = 2'b00;
        check("bsy_one_cycle_after_start", 32'(bsy), 32'h1);
        for (int i = 0; i < 32; i++) send_bit(1'b1);
        settle();
        read(BASE, d);
        check("ones_word0", d, 32'hFFFF_FFFF);
        check("ones_bsy_still_set", 32'(bsy), 32'(m_busy));

        // Alternating pattern, first bit 1
        cmd(2'b10);
        cmd(2'b01);
        for (int i = 0; i < 64; i++) send_bit((i % 2) == 0);
        settle();
        read(BASE, d);
        check("alt_word0", d, 32'hAAAA_AAAA);
        read(BASE + 32'h4, d);
        check("alt_word1", d, 32'hAAAA_AAAA);
        read(BASE + 32'h6, d);
        check("alt_word1_unaligned", d, 32'hAAAA_AAAA);

        // Clear (encoding 11) after 40 edges, restart with 32 zeros
        cmd(2'b01);
        for (int i = 0; i < 40; i++) send_bit(1'b1);
        settle();
        cmd(2'b11);
        check("bsy_after_clear11", 32'(bsy), 32'h0);
        cmd(2'b01);
        for (int i = 0; i < 32; i++) send_bit(1'b0);
        settle();
        read(BASE, d);
        check("restart_word0_zero", d, 32'h0);
        read(BASE + 32'h4, d);
        check("restart_word1_kept", d, 32'hAAAA_AAAA);

        // Start mid-capture is ignored
        cmd(2'b10);
        cmd(2'b01);
        for (int i = 0; i < 16; i++) send_bit(1'($urandom));
        cmd(2'b01);
        for (int i = 0; i < 48; i++) send_bit(1'($urandom));
        settle();
        read(BASE, d);
        check("midstart_word0", d, m_mem[0]);
        read(BASE + 32'h4, d);
        check("midstart_word1", d, m_mem[1]);

        // Random full capture
        cmd(2'b10);
        cmd(2'b01);
        for (int i = 0; i < DEPTH*32; i++) begin
            cap_bits[i] = 1'($urandom);
            send_bit(cap_bits[i]);
        end
        settle();
        check("full_bsy_low", 32'(bsy), 32'h0);
        for (int w = 0; w < DEPTH; w++) begin
            read(BASE + 32'(w*4), d);
            check($sformatf("full_word%0d", w), d, m_mem[w]);
        end
        for (int i = 0; i < 32; i++) send_bit(1'($urandom));
        settle();
        check("post_full_bsy", 32'(bsy), 32'h0);
        read(BASE, d);
        check("post_full_word0", d, m_mem[0]);
        read(BASE + 32'((DEPTH-1)*4), d);
        check("post_full_last", d, m_mem[DEPTH-1]);

        // Complemented full capture: bsy falls one cycle before dout shows the last word
        cmd(2'b10);
        cmd(2'b01);
        @(negedge AHBclk);
        addr = BASE + 32'((DEPTH-1)*4);
        target = ~m_mem[DEPTH-1];
        fall_cyc = -1;
        hit_cyc = -1;
        watch = 1;
        for (int i = 0; i < DEPTH*32; i++) send_bit(~cap_bits[i]);
        settle();
        watch = 0;
        check("last_write_bsy_fell", 32'(fall_cyc >= 0), 32'h1);
        check("last_write_dout_lag", 32'(hit_cyc - fall_cyc), 32'h1);
        check("last_word_model", target, m_mem[DEPTH-1]);

        // Address decode table
        tbl[0] = '{a: 32'h3FFF_FFFC, e: 32'h0, n: "below_base"};
        tbl[1] = '{a: BASE + 32'(DEPTH*4), e: 32'h0, n: "past_end"};
        tbl[2] = '{a: BASE + 32'(DEPTH*4) - 32'h1, e: m_mem[DEPTH-1], n: "last_byte"};
        tbl[3] = '{a: BASE + 32'h3, e: m_mem[0], n: "word0_byte3"};
        tbl[4] = '{a: 32'hFFFF_FFFC, e: 32'h0, n: "top_of_map"};
        tbl[5] = '{a: BASE + 32'h0E, e: m_mem[3], n: "word3_byte2"};
        for (int i = 0; i < 6; i++) begin
            read(tbl[i].a, d);
            check(tbl[i].n, d, tbl[i].e);
        end

        // Asynchronous reset mid-capture
        cmd(2'b10);
        cmd(2'b01);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom));
        addr = BASE;
        @(negedge AHBclk);
        check("bsy_before_async_rst", 32'(bsy), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_bsy", 32'(bsy), 32'h0);
        check("async_rst_dout", dout, 32'h0);
        @(negedge AHBclk);
        rst = 1'b1;
        model_clear();
        repeat (3) @(negedge AHBclk);
        check("bsy_after_async_release", 32'(bsy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
